cfu_responder: RTL and testbench

Custom Function Unit responder attached to the CVA5 CFU request/response port. It accepts one request at a time from the core, decodes the function, and computes the result: single-cycle for ADD, SUB, POPCNT and BSWAP, 32-cycle iterative for MUL. It returns the result with the request's id and a status code, holding it until the core accepts it. The block plugs directly onto the top-level `cfu_*` pins of the board wrapper.

---
 rtl/cfu_responder_if.sv | 46 ++++
 rtl/cfu_responder.sv | 171 +++++++++++++++++
 tb/tb_cfu_responder.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfu_responder_if.sv
//------------------------------------------------------------------------------
// Module      : cfu_responder_if
// Description : CVA5 CFU request/response bundle. The core drives the master
//               modport and the responder sits on the slave modport.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface cfu_responder_if;
    // Request channel
    logic        cfu_req_valid;
    logic        cfu_req_ready;
    logic        cfu_req_cfu_csr;
    logic [8:0]  cfu_req_id;
    logic [7:0]  cfu_req_cfu;
    logic [7:0]  cfu_req_state;
    logic [9:0]  cfu_req_func;
    logic [31:0] cfu_req_insn;
    logic [31:0] cfu_req_data0;
    logic [31:0] cfu_req_data1;
    // Response channel
    logic        cfu_resp_valid;
    logic        cfu_resp_ready;
    logic [8:0]  cfu_resp_id;
    logic [2:0]  cfu_resp_status;
    logic [31:0] cfu_resp_data;

    modport master (
        output cfu_req_valid, cfu_req_cfu_csr, cfu_req_id, cfu_req_cfu,
               cfu_req_state, cfu_req_func, cfu_req_insn, cfu_req_data0,
               cfu_req_data1, cfu_resp_ready,
        input  cfu_req_ready, cfu_resp_valid, cfu_resp_id, cfu_resp_status,
               cfu_resp_data
    );

    modport slave (
        input  cfu_req_valid, cfu_req_cfu_csr, cfu_req_id, cfu_req_cfu,
               cfu_req_state, cfu_req_func, cfu_req_insn, cfu_req_data0,
               cfu_req_data1, cfu_resp_ready,
        output cfu_req_ready, cfu_resp_valid, cfu_resp_id, cfu_resp_status,
               cfu_resp_data
    );
endinterface

`default_nettype wire

// File: rtl/cfu_responder.sv
//------------------------------------------------------------------------------
// Module      : cfu_responder
// Description : CFU responder. One request in flight; ADD/SUB/POPCNT/BSWAP
//               complete in one cycle, MUL runs a 32-step shift-add. The
//               response is held until the core takes it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cfu_responder #(
    parameter logic [7:0] CFU_ID = 8'd0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    cfu_responder_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] c_FUNC_ADD    = 3'd0;
    localparam logic [2:0] c_FUNC_SUB    = 3'd1;
    localparam logic [2:0] c_FUNC_MUL    = 3'd2;
    localparam logic [2:0] c_FUNC_POPCNT = 3'd3;
    localparam logic [2:0] c_FUNC_BSWAP  = 3'd4;

    localparam logic [2:0] c_STATUS_OK  = 3'b000;
    localparam logic [2:0] c_STATUS_ERR = 3'b001;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [8:0]  r_id;
    logic [2:0]  r_status;
    logic [31:0] r_data;
    logic [31:0] r_opa;      // multiplicand, shifted left each MUL step
    logic [31:0] r_opb;      // multiplier, shifted right each MUL step
    logic [31:0] r_prod;
    logic [4:0]  r_cnt;

    logic        w_req_ready;
    logic        w_resp_valid;
    logic        w_accept;
    logic        w_resp_hs;
    logic        w_err;
    logic        w_is_mul;
    logic        w_mul_last;
    logic [31:0] w_prod_next;
    logic [5:0]  w_popcnt;
    logic [31:0] w_result;

    // State and operand fields that carry no meaning for this unit
    logic        w_unused_ok;
    assign w_unused_ok = ^{bus.cfu_req_state, bus.cfu_req_insn};

    assign w_accept   = bus.cfu_req_valid && w_req_ready;
    assign w_resp_hs  = w_resp_valid && bus.cfu_resp_ready;
    assign w_mul_last = (r_cnt == 5'd31);

    assign w_err = bus.cfu_req_cfu_csr
                || (bus.cfu_req_cfu != CFU_ID)
                || (bus.cfu_req_func[9:3] != 7'd0)
                || (bus.cfu_req_func[2:0] > c_FUNC_BSWAP);

    assign w_is_mul = (bus.cfu_req_func[2:0] == c_FUNC_MUL);

    // One shift-add step: add the multiplicand when the current multiplier bit is set
    assign w_prod_next = r_prod + (r_opb[0] ? r_opa : 32'd0);

    // Population count of operand A
    always_comb begin
        w_popcnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            w_popcnt = w_popcnt + {5'd0, bus.cfu_req_data0[i]};
        end
    end

    // Single-cycle result selection; errors force zero data
    always_comb begin
        w_result = 32'd0;
        if (!w_err) begin
            case (bus.cfu_req_func[2:0])
                c_FUNC_ADD:    w_result = bus.cfu_req_data0 + bus.cfu_req_data1;
                c_FUNC_SUB:    w_result = bus.cfu_req_data0 - bus.cfu_req_data1;
                c_FUNC_POPCNT: w_result = {26'd0, w_popcnt};
                c_FUNC_BSWAP:  w_result = {bus.cfu_req_data0[7:0],   bus.cfu_req_data0[15:8],
                                           bus.cfu_req_data0[23:16], bus.cfu_req_data0[31:24]};
                default:       w_result = 32'd0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_is_mul && !w_err) ? S_BUSY : S_RESP;
                end
            end
            S_BUSY: begin
                if (w_mul_last) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (w_resp_hs) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        w_req_ready  = (r_state == S_IDLE) && !rst;
        w_resp_valid = (r_state == S_RESP);
    end

    // Datapath: capture request, iterate multiply, hold response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id     <= 9'd0;
            r_status <= 3'd0;
            r_data   <= 32'd0;
            r_opa    <= 32'd0;
            r_opb    <= 32'd0;
            r_prod   <= 32'd0;
            r_cnt    <= 5'd0;
        end else begin
            if ((r_state == S_IDLE) && w_accept) begin
                r_id   <= bus.cfu_req_id;
                r_opa  <= bus.cfu_req_data0;
                r_opb  <= bus.cfu_req_data1;
                r_prod <= 32'd0;
                r_cnt  <= 5'd0;
                r_status <= w_err ? c_STATUS_ERR : c_STATUS_OK;
                r_data   <= w_result;
            end else if (r_state == S_BUSY) begin
                r_prod <= w_prod_next;
                r_opa  <= {r_opa[30:0], 1'b0};
                r_opb  <= {1'b0, r_opb[31:1]};
                r_cnt  <= r_cnt + 5'd1;
                if (w_mul_last) begin
                    r_data <= w_prod_next;
                end
            end
        end
    end

    assign bus.cfu_req_ready   = w_req_ready;
    assign bus.cfu_resp_valid  = w_resp_valid;
    assign bus.cfu_resp_id     = r_id;
    assign bus.cfu_resp_status = r_status;
    assign bus.cfu_resp_data   = r_data;

endmodule

`default_nettype wire

// File: tb/tb_cfu_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_cfu_responder
// Description : Self-checking bench for cfu_responder with a response
//               scoreboard and per-scenario timing checks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cfu_responder;

    localparam logic [7:0] c_CFU = 8'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cfu_responder_if bus();

    cfu_responder #(.CFU_ID(c_CFU)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [8:0]  id;
        logic [2:0]  st;
        logic [31:0] d;
    } resp_t;

    resp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int hs_cyc = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc++;

    // Reference model of the unit's response
    function automatic resp_t model(input logic [8:0] id, input logic [7:0] cfu,
                                    input logic csr, input logic [9:0] func,
                                    input logic [31:0] a, input logic [31:0] b);
        resp_t r;
        r.id = id;
        r.st = 3'b000;
        r.d  = 32'd0;
        if (csr || cfu != c_CFU || func > 10'd4) begin
            r.st = 3'b001;
        end else begin
            case (func)
                10'd0: r.d = a + b;
                10'd1: r.d = a - b;
                10'd2: r.d = a * b;
                10'd3: r.d = 32'($countones(a));
                default: r.d = {a[7:0], a[15:8], a[23:16], a[31:24]};
            endcase
        end
        return r;
    endfunction

    // Scoreboard: compare every response handshake against the queue
    always @(negedge clk) begin
        resp_t got;
        resp_t exp;
        if (!rst && bus.cfu_resp_valid && bus.cfu_resp_ready) begin
            got = {bus.cfu_resp_id, bus.cfu_resp_status, bus.cfu_resp_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected got id=%h st=%h d=%h", got.id, got.st, got.d);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL resp_payload got id=%h st=%h d=%h want id=%h st=%h d=%h",
                             got.id, got.st, got.d, exp.id, exp.st, exp.d);
                end
            end
            hs_cyc = cyc + 1;
        end
    end

    task automatic drive(input logic [8:0] id, input logic [7:0] cfu, input logic csr,
                         input logic [9:0] func, input logic [31:0] a, input logic [31:0] b);
        bus.cfu_req_valid   = 1'b1;
        bus.cfu_req_id      = id;
        bus.cfu_req_cfu     = cfu;
        bus.cfu_req_cfu_csr = csr;
        bus.cfu_req_func    = func;
        bus.cfu_req_data0   = a;
        bus.cfu_req_data1   = b;
        bus.cfu_req_state   = 8'($urandom);
        bus.cfu_req_insn    = $urandom;
    endtask

    // Wait for the pending request to be taken; returns 1ns after the accepting edge
    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!bus.cfu_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.cfu_req_ready) begin
            errors++;
            $display("FAIL accept_timeout got ready=%b want 1", bus.cfu_req_ready);
            bus.cfu_req_valid = 1'b0;
        end else begin
            exp_q.push_back(model(bus.cfu_req_id, bus.cfu_req_cfu, bus.cfu_req_cfu_csr,
                                  bus.cfu_req_func, bus.cfu_req_data0, bus.cfu_req_data1));
            acc_cyc = cyc + 1;
            @(posedge clk);
            #1;
            bus.cfu_req_valid = 1'b0;
        end
    endtask

    task automatic issue(input logic [8:0] id, input logic [7:0] cfu, input logic csr,
                         input logic [9:0] func, input logic [31:0] a, input logic [31:0] b);
        drive(id, cfu, csr, func, a, b);
        wait_accept();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.cfu_req_ready !== 1'b0 || bus.cfu_resp_valid !== 1'b0 ||
                bus.cfu_resp_id !== 9'd0 || bus.cfu_resp_status !== 3'd0 ||
                bus.cfu_resp_data !== 32'd0) begin
                errors++;
                $display("FAIL reset_outputs got ready=%b valid=%b id=%h st=%h d=%h want all 0",
                         bus.cfu_req_ready, bus.cfu_resp_valid, bus.cfu_resp_id,
                         bus.cfu_resp_status, bus.cfu_resp_data);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cfu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 1", bus.cfu_req_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        bus.cfu_resp_ready = 1'b1;
        issue(9'h1A5, c_CFU, 1'b0, 10'd0, 32'hFFFF_FFFF, 32'd2);
        @(negedge clk);
        checks++;
        if (bus.cfu_resp_valid !== 1'b1 || bus.cfu_req_ready !== 1'b0 ||
            bus.cfu_resp_data !== 32'h1) begin
            errors++;
            $display("FAIL add_t1 got valid=%b ready=%b d=%h want 1 0 00000001",
                     bus.cfu_resp_valid, bus.cfu_req_ready, bus.cfu_resp_data);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bus.cfu_req_ready !== 1'b1 || bus.cfu_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_t2 got ready=%b valid=%b want 1 0",
                     bus.cfu_req_ready, bus.cfu_resp_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        logic bad;
        bad = 1'b0;
        bus.cfu_resp_ready = 1'b1;
        issue(9'h033, c_CFU, 1'b0, 10'd2, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (bus.cfu_resp_valid !== 1'b0 || bus.cfu_req_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL mul_busy_window got early valid/ready in T+1..T+32 want none");
        end
        @(negedge clk);
        checks++;
        if (bus.cfu_resp_valid !== 1'b1 || bus.cfu_req_ready !== 1'b0 ||
            bus.cfu_resp_data !== 32'h242D_2080 || bus.cfu_resp_status !== 3'd0) begin
            errors++;
            $display("FAIL mul_t33 got valid=%b ready=%b d=%h st=%h want 1 0 242d2080 0",
                     bus.cfu_resp_valid, bus.cfu_req_ready, bus.cfu_resp_data, bus.cfu_resp_status);
        end
        wait_drain();
        // Extremes of the multiplier
        issue(9'h034, c_CFU, 1'b0, 10'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_drain();
        issue(9'h035, c_CFU, 1'b0, 10'd2, 32'h8000_0001, 32'd0);
        wait_drain();
    endtask

    task automatic test_popcnt_bswap();
        bus.cfu_resp_ready = 1'b1;
        issue(9'h101, c_CFU, 1'b0, 10'd3, 32'hF0F0_000F, 32'd0);
        @(negedge clk);
        checks++;
        if (bus.cfu_resp_data !== 32'd12) begin
            errors++;
            $display("FAIL popcnt got %0d want 12", bus.cfu_resp_data);
        end
        wait_drain();
        issue(9'h102, c_CFU, 1'b0, 10'd3, 32'hFFFF_FFFF, 32'd0);
        wait_drain();
        issue(9'h103, c_CFU, 1'b0, 10'd3, 32'h0, 32'd7);
        wait_drain();
        issue(9'h104, c_CFU, 1'b0, 10'd4, 32'h1122_3344, 32'd0);
        @(negedge clk);
        checks++;
        if (bus.cfu_resp_data !== 32'h4433_2211) begin
            errors++;
            $display("FAIL bswap got %h want 44332211", bus.cfu_resp_data);
        end
        wait_drain();
        issue(9'h105, c_CFU, 1'b0, 10'd1, 32'd5, 32'd7);
        wait_drain();
    endtask

    task automatic test_errors();
        logic [7:0] cfus [4];
        logic       csrs [4];
        logic [9:0] funcs[4];
        cfus  = '{c_CFU + 8'd1, c_CFU, c_CFU, c_CFU};
        csrs  = '{1'b0, 1'b0, 1'b1, 1'b0};
        funcs = '{10'd0, 10'd5, 10'd0, 10'h008};
        bus.cfu_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(9'(9'h1E0 + i), cfus[i], csrs[i], funcs[i], 32'hDEAD_BEEF, 32'h1);
            @(negedge clk);
            checks++;
            if (bus.cfu_resp_valid !== 1'b1 || bus.cfu_resp_status !== 3'b001 ||
                bus.cfu_resp_data !== 32'd0) begin
                errors++;
                $display("FAIL error_case%0d got valid=%b st=%h d=%h want 1 1 0",
                         i, bus.cfu_resp_valid, bus.cfu_resp_status, bus.cfu_resp_data);
            end
            wait_drain();
        end
    endtask

    task automatic test_back_to_back();
        int prev;
        bus.cfu_resp_ready = 1'b1;
        issue(9'h010, c_CFU, 1'b0, 10'd1, $urandom, $urandom);
        prev = acc_cyc;
        for (int i = 1; i < 5; i++) begin
            issue(9'(9'h010 + i), c_CFU, 1'b0, 10'(i % 2), $urandom, $urandom);
            checks++;
            if (acc_cyc - prev != 2) begin
                errors++;
                $display("FAIL b2b_spacing got %0d want 2", acc_cyc - prev);
            end
            prev = acc_cyc;
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        bus.cfu_resp_ready = 1'b0;
        issue(9'h055, c_CFU, 1'b0, 10'd0, 32'd100, 32'd23);
        drive(9'h0AA, c_CFU, 1'b0, 10'd4, 32'hA1B2_C3D4, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.cfu_resp_valid !== 1'b1 || bus.cfu_req_ready !== 1'b0 ||
                bus.cfu_resp_id !== 9'h055 || bus.cfu_resp_status !== 3'd0 ||
                bus.cfu_resp_data !== 32'd123) begin
                errors++;
                $display("FAIL stall_hold got valid=%b ready=%b id=%h st=%h d=%h want 1 0 055 0 0000007b",
                         bus.cfu_resp_valid, bus.cfu_req_ready, bus.cfu_resp_id,
                         bus.cfu_resp_status, bus.cfu_resp_data);
            end
        end
        @(posedge clk);
        #1;
        bus.cfu_resp_ready = 1'b1;
        wait_accept();
        checks++;
        if (acc_cyc - hs_cyc != 1) begin
            errors++;
            $display("FAIL stall_reaccept got %0d want 1", acc_cyc - hs_cyc);
        end
        wait_drain();
    endtask

    task automatic test_reset_abort();
        logic bad;
        bus.cfu_resp_ready = 1'b1;
        issue(9'h0C1, c_CFU, 1'b0, 10'd2, 32'd7, 32'd9);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.cfu_resp_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_busy got resp_valid after reset want none");
        end
        @(posedge clk);
        #1;
        // Abort while a response is being held
        bus.cfu_resp_ready = 1'b0;
        issue(9'h0C2, c_CFU, 1'b0, 10'd0, 32'd1, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cfu_resp_valid !== 1'b0 || bus.cfu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_resp got valid=%b ready=%b want 0 1",
                     bus.cfu_resp_valid, bus.cfu_req_ready);
        end
        @(posedge clk);
        #1;
        bus.cfu_resp_ready = 1'b1;
        issue(9'h0C3, c_CFU, 1'b0, 10'd2, 32'hCAFE_F00D, 32'h0000_0101);
        wait_drain();
    endtask

    initial begin
        bus.cfu_req_valid   = 1'b0;
        bus.cfu_req_id      = 9'd0;
        bus.cfu_req_cfu     = 8'd0;
        bus.cfu_req_cfu_csr = 1'b0;
        bus.cfu_req_func    = 10'd0;
        bus.cfu_req_data0   = 32'd0;
        bus.cfu_req_data1   = 32'd0;
        bus.cfu_req_state   = 8'd0;
        bus.cfu_req_insn    = 32'd0;
        bus.cfu_resp_ready  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_mul();
        test_popcnt_bswap();
        test_errors();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue got pending=%0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
